// File: rtl/sc_sync_controller.sv
// Schmidl-Cox sync sequencer: finds a metric crossing, tracks the peak over a
// fixed window, skips to the frame start and forwards one packet of samples.
module sc_sync_controller #(
  parameter int METRIC_WIDTH = 40,
  parameter int PEAK_WIN     = 128,
  parameter int START_OFFSET = 1024,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [METRIC_WIDTH-1:0] threshold,
  input  logic [LEN_WIDTH-1:0]    frame_len,
  input  logic [METRIC_WIDTH-1:0] m_tdata,
  input  logic                    m_tlast,
  input  logic                    m_tvalid,
  output logic                    m_tready,
  input  logic [31:0]             s_tdata,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [31:0]             o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    detect,
  output logic [METRIC_WIDTH-1:0] peak_metric,
  output logic                    busy
);

  if (START_OFFSET < PEAK_WIN) begin : g_bad_offset
    $error("sc_sync_controller: START_OFFSET must be >= PEAK_WIN");
  end

  typedef enum logic [1:0] {SEARCH, PEAK, SKIP, FORWARD} state_t;

  localparam logic [LEN_WIDTH-1:0] ONE       = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LAST_OFF  = LEN_WIDTH'(PEAK_WIN - 1);
  localparam logic [LEN_WIDTH-1:0] SKIP_BASE = LEN_WIDTH'(START_OFFSET - PEAK_WIN);

  state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]    win_cnt, win_nxt;
  logic [LEN_WIDTH-1:0]    peak_off, off_nxt;
  logic [LEN_WIDTH-1:0]    skip_cnt, skip_nxt;
  logic [LEN_WIDTH-1:0]    fwd_cnt, fwd_nxt;
  logic [LEN_WIDTH-1:0]    len_lat, len_nxt;
  logic [METRIC_WIDTH-1:0] max_metric, max_nxt;
  logic [METRIC_WIDTH-1:0] peak_nxt;
  logic                    detect_nxt;

  logic                    advance, beat, better;
  logic [LEN_WIDTH-1:0]    off_upd, skip_upd;
  logic [METRIC_WIDTH-1:0] max_upd;
  logic                    unused_tlast;

  // Both streams move together; a stalled output freezes them only in FORWARD.
  assign advance  = (state != FORWARD) || o_tready;
  assign m_tready = s_tvalid && advance;
  assign s_tready = m_tvalid && advance;
  assign beat     = m_tvalid && s_tvalid && advance;

  assign o_tvalid = (state == FORWARD) && m_tvalid && s_tvalid;
  assign o_tdata  = s_tdata;
  assign o_tlast  = o_tvalid && (fwd_cnt == len_lat - ONE);
  assign busy     = (state != SEARCH);

  // Strict compare keeps the earliest of equal maxima.
  assign better   = m_tdata > max_metric;
  assign off_upd  = better ? win_cnt : peak_off;
  assign max_upd  = better ? m_tdata : max_metric;
  assign skip_upd = off_upd + SKIP_BASE;

  assign unused_tlast = m_tlast ^ s_tlast;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    state_nxt  = state;
    win_nxt    = win_cnt;
    off_nxt    = peak_off;
    skip_nxt   = skip_cnt;
    fwd_nxt    = fwd_cnt;
    len_nxt    = len_lat;
    max_nxt    = max_metric;
    peak_nxt   = peak_metric;
    detect_nxt = 1'b0;

    if (clear) begin
      state_nxt = SEARCH;
      win_nxt   = '0;
      off_nxt   = '0;
      skip_nxt  = '0;
      fwd_nxt   = '0;
    end else if (beat) begin
      unique case (state)
        SEARCH: begin
          if (m_tdata > threshold) begin
            state_nxt = PEAK;
            win_nxt   = ONE;
            max_nxt   = m_tdata;
            off_nxt   = '0;
            len_nxt   = (frame_len == '0) ? ONE : frame_len;
          end
        end
        PEAK: begin
          max_nxt = max_upd;
          off_nxt = off_upd;
          win_nxt = win_cnt + ONE;
          if (win_cnt == LAST_OFF) begin
            detect_nxt = 1'b1;
            peak_nxt   = max_upd;
            skip_nxt   = skip_upd;
            state_nxt  = (skip_upd == '0) ? FORWARD : SKIP;
          end
        end
        SKIP: begin
          skip_nxt = skip_cnt - ONE;
          if (skip_cnt == ONE) state_nxt = FORWARD;
        end
        FORWARD: begin
          if (o_tlast) begin
            fwd_nxt   = '0;
            state_nxt = SEARCH;
          end else begin
            fwd_nxt = fwd_cnt + ONE;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEARCH;
      win_cnt     <= '0;
      peak_off    <= '0;
      skip_cnt    <= '0;
      fwd_cnt     <= '0;
      len_lat     <= '0;
      max_metric  <= '0;
      peak_metric <= '0;
      detect      <= 1'b0;
    end else begin
      state       <= state_nxt;
      win_cnt     <= win_nxt;
      peak_off    <= off_nxt;
      skip_cnt    <= skip_nxt;
      fwd_cnt     <= fwd_nxt;
      len_lat     <= len_nxt;
      max_metric  <= max_nxt;
      peak_metric <= peak_nxt;
      detect      <= detect_nxt;
    end
  end

endmodule

// File: doc/sc_sync_controller.md
Name: sc_sync_controller

Overview:
- Sequencing controller placed after the Schmidl-Cox metric calculator.
- Consumes two lockstep streams: the averaged metric M(d) and the latency-matched sample stream.
- Searches for a metric crossing above threshold, tracks the peak over a fixed window, then skips to the frame start.
- Forwards exactly frame_len samples as one AXI-Stream packet and returns to search; all other samples are dropped.

Parameters:
- METRIC_WIDTH, 40 (= 32+$clog2(CP_SIZE+1) with CP_SIZE=128): metric stream width.
- PEAK_WIN, 128: number of beats in the peak-tracking window, counted from the first crossing (offsets 0..PEAK_WIN-1).
- START_OFFSET, 1024: beats from the peak beat to the first forwarded sample. Elaboration error if START_OFFSET < PEAK_WIN.
- LEN_WIDTH, 16: width of frame_len and the internal counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear to the SEARCH state.
- threshold  in  METRIC_WIDTH  detection threshold, unsigned.
- frame_len  in  LEN_WIDTH  number of samples forwarded per detection.
- m_tdata  in  METRIC_WIDTH  metric sample M(d).
- m_tlast  in  1  ignored.
- m_tvalid  in  1  metric valid.
- m_tready  out  1  metric accept.
- s_tdata  in  32  sample aligned with m_tdata (I/Q, 16+16).
- s_tlast  in  1  ignored.
- s_tvalid  in  1  sample valid.
- s_tready  out  1  sample accept.
- o_tdata  out  32  forwarded sample.
- o_tlast  out  1  last sample of the frame.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output accept.
- detect  out  1  one-cycle pulse on peak decision.
- peak_metric  out  METRIC_WIDTH  maximum metric of the last detection.
- busy  out  1  high in any state other than SEARCH.

Behaviour:
- Beat: a cycle with m_tvalid && s_tvalid && (state != FORWARD || o_tready).
  - m_tready = s_tready = s_tvalid/m_tvalid partner && (state != FORWARD || o_tready); that is, m_tready depends on s_tvalid and s_tready depends on m_tvalid.
  - The two streams are never consumed independently.
- Output path (combinational pass-through):
  - o_tvalid = (state == FORWARD) && m_tvalid && s_tvalid.
  - o_tdata = s_tdata.
  - o_tlast = o_tvalid && (fwd_cnt == len_lat - 1).
- States: SEARCH, PEAK, SKIP, FORWARD. Reset and clear both go to SEARCH.
- Reset values: state = SEARCH; all counters 0; detect = 0; busy = 0; peak_metric = 0; o_tvalid = 0 (follows from state).
- SEARCH:
  - On a beat with m_tdata > threshold (unsigned, strict): go to PEAK.
  - On that transition: win_cnt = 1; max = m_tdata; peak_off = 0; latch len_lat = frame_len (0 is latched as 1).
  - threshold is sampled only on SEARCH beats; frame_len is sampled only at this transition.
- PEAK:
  - Each beat: if m_tdata > max, update max and set peak_off = win_cnt. Strict compare, so the first maximum wins.
  - Increment win_cnt on each beat.
  - The beat at offset PEAK_WIN-1 is the last beat in PEAK.
  - After that beat: detect = 1 for exactly one cycle; peak_metric = max; skip_cnt = peak_off + START_OFFSET - PEAK_WIN.
  - If skip_cnt == 0, go to FORWARD; otherwise go to SKIP.
  - Samples in PEAK are dropped, whether or not they are above threshold.
- SKIP: drop one beat per decrement of skip_cnt; go to FORWARD after the beat that brings it to 0.
- FORWARD:
  - Each beat transfers one sample; fwd_cnt increments.
  - On the o_tlast beat: fwd_cnt = 0 and return to SEARCH.
  - A new detection can start on the very next beat.
- Timing: the first forwarded sample is the beat at crossing + peak_off + START_OFFSET.
- Backpressure: during FORWARD, o_tready low stalls both input streams. No sample is lost, duplicated or reordered.
- Arithmetic: counters are LEN_WIDTH bits and do not wrap within the legal parameter range. m_tlast and s_tlast have no effect.
- Reset and clear mid-operation:
  - reset_n low: asynchronous return to SEARCH. o_tvalid falls in the same cycle; no o_tlast is emitted for the truncated frame.
  - clear: same effect at the next clock edge.
  - A clear in the same cycle as a beat takes priority; the beat is consumed but has no effect.

Test Plan:
1. Noise only: metric = 500 with threshold = 1000 for 5000 beats -> every beat accepted, o_tvalid never high, detect never high, busy = 0.
2. Single detection: threshold = 1000, crossing at beat 100, max = 5000 at offset 10, PEAK_WIN = 128, START_OFFSET = 1024, frame_len = 16 -> detect pulses after beat 227, peak_metric = 5000; samples 1134..1149 are forwarded with o_tlast on 1149; then busy = 0.
3. Backpressure: scenario 2 with o_tready toggling at a random 50% duty -> same 16 samples in order; m_tready and s_tready are low whenever state is FORWARD and o_tready is low.
4. Tie and edge values:
   - Equal maxima of 7000 at offsets 5 and 20 -> first sample forwarded at crossing + 1029.
   - Peak at offset 0 with START_OFFSET = PEAK_WIN -> skip_cnt = 0 and the next beat goes straight to FORWARD.
   - frame_len = 0 -> exactly one sample forwarded, with o_tlast set.
5. Stream skew: s_tvalid = 1, m_tvalid = 0 for 50 cycles -> neither stream consumed, no state change; m_tvalid = 1, s_tvalid = 0 -> same result.
6. Reset and clear:
   - reset_n pulsed low after 8 forwarded samples -> o_tvalid = 0 immediately, detect = 0, and a subsequent detection behaves exactly as in scenario 2.
   - clear in the same situation -> same result one cycle later.
